rv_mem_arbiter: RTL and testbench

- Shares one single-port, request/acknowledge memory bus between the CPU's instruction-fetch interface and data-memory interface.
- Sits between the core top level and the memory/bus fabric; the core sees its usual im_* and dm_* ports unchanged.
- Sequences accesses with a small FSM, data-priority arbitration and a one-shot fairness rule toward fetch.
- Discards stale fetches after branches and aborts hung accesses with a timeout.

---
 rtl/rv_mem_arbiter_pkg.sv | 33 +++
 rtl/rv_arb_timeout.sv | 29 ++
 rtl/rv_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_rv_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_arbiter_pkg.sv
// Shared definitions for the RV memory-bus arbiter: FSM encodings, bus request
// payload and default timeout settings.
package rv_defs;

   localparam int unsigned RV_XLEN                 = 32;
   localparam int unsigned RV_SEL_W                = 4;
   localparam int unsigned RV_ARB_TIMEOUT_DEFAULT  = 255;
   localparam int unsigned RV_ARB_TO_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      RV_ARB_IDLE   = 2'd0,
      RV_ARB_IFETCH = 2'd1,
      RV_ARB_DACC   = 2'd2
   } rv_arb_state_e;

   typedef struct packed {
      logic                  we;
      logic [RV_SEL_W-1:0]   sel;
      logic [RV_XLEN-1:0]    addr;
      logic [RV_XLEN-1:0]    wdata;
   } rv_mem_req_t;

   // Instruction fetches are full-word reads.
   function automatic rv_mem_req_t rv_fetch_req(input logic [RV_XLEN-1:0] addr);
      rv_mem_req_t r;
      r.we    = 1'b0;
      r.sel   = '1;
      r.addr  = addr;
      r.wdata = '0;
      return r;
   endfunction

endpackage

// File: rtl/rv_arb_timeout.sv
// Load/count/expire down-counter bounding how long a bus master waits for ack.
// A load value of zero never expires.
module rv_arb_timeout #(
   parameter int unsigned TO_WIDTH = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load,
   input  logic [TO_WIDTH-1:0] load_val,
   input  logic                count,
   output logic                expired_c
);

   logic [TO_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (count && (cnt_q != '0)) begin
         cnt_q <= cnt_q - TO_WIDTH'(1);
      end
   end

   // Expires on the cycle that would consume the last remaining count.
   assign expired_c = count && (cnt_q == TO_WIDTH'(1));

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one request/acknowledge memory bus between instruction fetch and data
// access, with data priority, one-shot fetch fairness and an access timeout.
module rv_mem_arbiter
   import rv_defs::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = RV_ARB_TIMEOUT_DEFAULT,
   parameter int unsigned TO_WIDTH       = RV_ARB_TO_WIDTH_DEFAULT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [RV_XLEN-1:0]   im_addr_i,
   output logic [RV_XLEN-1:0]   im_data_o,
   output logic                 im_valid_o,
   input  logic [RV_XLEN-1:0]   dm_addr_i,
   input  logic [RV_XLEN-1:0]   dm_data_s_i,
   input  logic [RV_SEL_W-1:0]  dm_data_select_i,
   input  logic                 dm_load_i,
   input  logic                 dm_store_i,
   output logic                 dm_ready_o,
   output logic [RV_XLEN-1:0]   dm_data_l_o,
   output logic                 dm_load_done_o,
   output logic                 dm_store_done_o,
   output logic [RV_XLEN-1:0]   mem_addr_o,
   output logic [RV_XLEN-1:0]   mem_wdata_o,
   output logic [RV_SEL_W-1:0]  mem_sel_o,
   output logic                 mem_we_o,
   output logic                 mem_req_o,
   input  logic                 mem_ack_i,
   input  logic [RV_XLEN-1:0]   mem_rdata_i,
   output logic                 bus_err_o,
   output logic                 proto_err_o
);

   rv_arb_state_e       state_q;
   logic                fair_q;
   logic [RV_XLEN-1:0]  fetch_addr_q;
   logic                pend_q;
   rv_mem_req_t         pend_req_q;

   logic                capture_c;
   logic                proto_viol_c;
   logic                wait_c;
   logic                expired_c;
   logic                done_c;
   logic                dacc_done_c;
   logic                pick_dacc_c;
   logic [RV_XLEN-1:0]  rdata_c;
   rv_mem_req_t         issue_c;

   assign capture_c    = (dm_load_i | dm_store_i) & dm_ready_o;
   assign proto_viol_c = (dm_load_i & dm_store_i) | ((dm_load_i | dm_store_i) & ~dm_ready_o);
   assign wait_c       = mem_req_o & ~mem_ack_i;
   assign done_c       = mem_req_o & (mem_ack_i | expired_c);
   assign dacc_done_c  = done_c & (state_q == RV_ARB_DACC);
   // An aborted access completes with all-zero read data.
   assign rdata_c      = mem_ack_i ? mem_rdata_i : '0;
   assign pick_dacc_c  = pend_q & ~fair_q;
   assign issue_c      = pick_dacc_c ? pend_req_q : rv_fetch_req(im_addr_i);

   rv_arb_timeout #(
      .TO_WIDTH (TO_WIDTH)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (state_q == RV_ARB_IDLE),
      .load_val  (TO_WIDTH'(TIMEOUT_CYCLES)),
      .count     (wait_c),
      .expired_c (expired_c)
   );

   // Data-port capture; a simultaneous load and store resolves to the store.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q      <= 1'b0;
         pend_req_q  <= '0;
         dm_ready_o  <= 1'b0;
         proto_err_o <= 1'b0;
      end else begin
         dm_ready_o <= ~(pend_q | capture_c);
         if (proto_viol_c) begin
            proto_err_o <= 1'b1;
         end
         if (capture_c) begin
            pend_q           <= 1'b1;
            pend_req_q.we    <= dm_store_i;
            pend_req_q.sel   <= dm_data_select_i;
            pend_req_q.addr  <= dm_addr_i;
            pend_req_q.wdata <= dm_data_s_i;
         end else if (dacc_done_c) begin
            pend_q <= 1'b0;
         end
      end
   end

   // Access sequencer with registered bus and completion outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= RV_ARB_IDLE;
         fair_q          <= 1'b0;
         fetch_addr_q    <= '0;
         mem_req_o       <= 1'b0;
         mem_we_o        <= 1'b0;
         mem_sel_o       <= '0;
         mem_addr_o      <= '0;
         mem_wdata_o     <= '0;
         im_data_o       <= '0;
         im_valid_o      <= 1'b0;
         dm_data_l_o     <= '0;
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         bus_err_o       <= 1'b0;
      end else begin
         im_valid_o      <= 1'b0;
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         if (expired_c) begin
            bus_err_o <= 1'b1;
         end
         case (state_q)
            RV_ARB_IDLE: begin
               mem_req_o   <= 1'b1;
               mem_we_o    <= issue_c.we;
               mem_sel_o   <= issue_c.sel;
               mem_addr_o  <= issue_c.addr;
               mem_wdata_o <= issue_c.wdata;
               if (pick_dacc_c) begin
                  state_q <= RV_ARB_DACC;
               end else begin
                  state_q      <= RV_ARB_IFETCH;
                  fetch_addr_q <= im_addr_i;
               end
            end
            RV_ARB_IFETCH: begin
               if (done_c) begin
                  mem_req_o <= 1'b0;
                  state_q   <= RV_ARB_IDLE;
                  fair_q    <= 1'b0;
                  // A redirected fetch is dropped silently.
                  if (im_addr_i == fetch_addr_q) begin
                     im_data_o  <= rdata_c;
                     im_valid_o <= 1'b1;
                  end
               end
            end
            RV_ARB_DACC: begin
               if (done_c) begin
                  mem_req_o <= 1'b0;
                  state_q   <= RV_ARB_IDLE;
                  fair_q    <= 1'b1;
                  if (mem_we_o) begin
                     dm_store_done_o <= 1'b1;
                  end else begin
                     dm_data_l_o    <= rdata_c;
                     dm_load_done_o <= 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= RV_ARB_IDLE;
               mem_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: fetch streaming, data priority and
// fairness, branch redirect, timeout abort, async reset and port protocol errors.
module tb_rv_mem_arbiter;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] im_addr_i;
   logic [31:0] im_data_o;
   logic        im_valid_o;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_data_s_i;
   logic [3:0]  dm_data_select_i;
   logic        dm_load_i;
   logic        dm_store_i;
   logic        dm_ready_o;
   logic [31:0] dm_data_l_o;
   logic        dm_load_done_o;
   logic        dm_store_done_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_sel_o;
   logic        mem_we_o;
   logic        mem_req_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        bus_err_o;
   logic        proto_err_o;

   int unsigned n_checks;
   int unsigned n_errors;

   // Bus model: ack after wait_n stalled cycles; read data = addr ^ 0x5A5A0000.
   logic        ack_en;
   int unsigned wait_n;
   int unsigned wcnt;

   rv_mem_arbiter #(
      .TIMEOUT_CYCLES (4),
      .TO_WIDTH       (8)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .im_addr_i        (im_addr_i),
      .im_data_o        (im_data_o),
      .im_valid_o       (im_valid_o),
      .dm_addr_i        (dm_addr_i),
      .dm_data_s_i      (dm_data_s_i),
      .dm_data_select_i (dm_data_select_i),
      .dm_load_i        (dm_load_i),
      .dm_store_i       (dm_store_i),
      .dm_ready_o       (dm_ready_o),
      .dm_data_l_o      (dm_data_l_o),
      .dm_load_done_o   (dm_load_done_o),
      .dm_store_done_o  (dm_store_done_o),
      .mem_addr_o       (mem_addr_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_sel_o        (mem_sel_o),
      .mem_we_o         (mem_we_o),
      .mem_req_o        (mem_req_o),
      .mem_ack_i        (mem_ack_i),
      .mem_rdata_i      (mem_rdata_i),
      .bus_err_o        (bus_err_o),
      .proto_err_o      (proto_err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   assign mem_ack_i   = mem_req_o && ack_en && (wcnt >= wait_n);
   assign mem_rdata_i = mem_ack_i ? (mem_addr_o ^ 32'h5A5A_0000) : 32'h0;

   always @(posedge clk_i) begin
      if (!mem_req_o || mem_ack_i) wcnt <= 0;
      else                         wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   initial begin
      logic [31:0] prev_l;
      logic [31:0] ld_addr;
      logic [31:0] ld_exp;
      n_checks = 0;
      n_errors = 0;
      wcnt     = 0;
      ack_en   = 1'b1;
      wait_n   = 0;
      rst_i    = 1'b1;
      im_addr_i        = 32'h100;
      dm_addr_i        = '0;
      dm_data_s_i      = '0;
      dm_data_select_i = '0;
      dm_load_i        = 1'b0;
      dm_store_i       = 1'b0;
      tick();
      tick();
      chk("rst_req",   32'(mem_req_o),  32'd0);
      chk("rst_ready", 32'(dm_ready_o), 32'd0);
      chk("rst_valid", 32'(im_valid_o), 32'd0);
      chk("rst_addr",  mem_addr_o,      32'd0);
      rst_i = 1'b0;

      // Zero-wait fetch streaming: request every other cycle, valid one later.
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("t1_req",   32'(mem_req_o),  32'(k % 2));
         chk("t1_valid", 32'(im_valid_o), 32'((k + 1) % 2));
         if (k % 2 == 1) begin
            chk("t1_addr", mem_addr_o,    32'h100);
            chk("t1_we",   32'(mem_we_o), 32'd0);
         end else begin
            chk("t1_data", im_data_o, 32'h5A5A_0100);
         end
      end

      // Store arriving during a fetch waits for the fetch, then goes out.
      tick();
      chk("t2_fetch_req", 32'(mem_req_o), 32'd1);
      dm_store_i = 1'b1; dm_addr_i = 32'h2000; dm_data_s_i = 32'hDEAD_BEEF; dm_data_select_i = 4'b0011;
      tick();
      dm_store_i = 1'b0;
      chk("t2_ready_lo0", 32'(dm_ready_o), 32'd0);
      chk("t2_fvalid",    32'(im_valid_o), 32'd1);
      chk("t2_req_idle",  32'(mem_req_o),  32'd0);
      tick();
      chk("t2_req",   32'(mem_req_o),   32'd1);
      chk("t2_we",    32'(mem_we_o),    32'd1);
      chk("t2_addr",  mem_addr_o,       32'h2000);
      chk("t2_wdata", mem_wdata_o,      32'hDEAD_BEEF);
      chk("t2_sel",   32'(mem_sel_o),   32'h3);
      chk("t2_ready_lo1", 32'(dm_ready_o), 32'd0);
      tick();
      chk("t2_done",      32'(dm_store_done_o), 32'd1);
      chk("t2_ready_lo2", 32'(dm_ready_o),      32'd0);
      chk("t2_req_off",   32'(mem_req_o),       32'd0);
      tick();
      chk("t2_done_off", 32'(dm_store_done_o), 32'd0);
      chk("t2_ready_hi", 32'(dm_ready_o),      32'd1);
      chk("t2_next_req", 32'(mem_req_o),       32'd1);
      chk("t2_next_adr", mem_addr_o,           32'h100);

      // Back-to-back loads strictly alternate with fetches.
      prev_l = 32'h0;
      for (int i = 0; i < 3; i++) begin
         ld_addr = 32'h3000 + 32'(4 * i);
         ld_exp  = 32'h5A5A_3000 + 32'(4 * i);
         dm_load_i = 1'b1; dm_addr_i = ld_addr;
         tick();
         dm_load_i = 1'b0;
         chk("t3_fvalid", 32'(im_valid_o), 32'd1);
         chk("t3_hold0",  dm_data_l_o,     prev_l);
         tick();
         chk("t3_req",   32'(mem_req_o), 32'd1);
         chk("t3_we",    32'(mem_we_o),  32'd0);
         chk("t3_addr",  mem_addr_o,     ld_addr);
         chk("t3_hold1", dm_data_l_o,    prev_l);
         tick();
         chk("t3_done", 32'(dm_load_done_o), 32'd1);
         chk("t3_data", dm_data_l_o,         ld_exp);
         tick();
         chk("t3_fetch",     mem_addr_o,          32'h100);
         chk("t3_fetch_req", 32'(mem_req_o),      32'd1);
         chk("t3_done_off",  32'(dm_load_done_o), 32'd0);
         chk("t3_ready",     32'(dm_ready_o),     32'd1);
         prev_l = ld_exp;
      end

      // Branch redirect while a fetch is stalled: result discarded.
      tick();
      chk("t4_pre_valid", 32'(im_valid_o), 32'd1);
      wait_n = 3;
      tick();
      chk("t4_req",  32'(mem_req_o), 32'd1);
      chk("t4_addr", mem_addr_o,     32'h100);
      im_addr_i = 32'h400;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("t4_wait_req", 32'(mem_req_o),  32'd1);
         chk("t4_novalid",  32'(im_valid_o), 32'd0);
      end
      tick();
      chk("t4_drop_valid", 32'(im_valid_o), 32'd0);
      chk("t4_drop_req",   32'(mem_req_o),  32'd0);
      tick();
      chk("t4_new_addr", mem_addr_o,     32'h400);
      chk("t4_new_req",  32'(mem_req_o), 32'd1);
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("t4_new_wait", 32'(im_valid_o), 32'd0);
      end
      tick();
      chk("t4_valid", 32'(im_valid_o), 32'd1);
      chk("t4_data",  im_data_o,       32'h5A5A_0400);

      // Load that never gets an ack: aborted after 4 request cycles.
      chk("t5_ready", 32'(dm_ready_o), 32'd1);
      wait_n = 0;
      dm_load_i = 1'b1; dm_addr_i = 32'h5000;
      tick();
      dm_load_i = 1'b0;
      chk("t5_fetch", mem_addr_o, 32'h400);
      tick();
      chk("t5_fvalid", 32'(im_valid_o), 32'd1);
      ack_en = 1'b0;
      tick();
      chk("t5_req",  32'(mem_req_o), 32'd1);
      chk("t5_addr", mem_addr_o,     32'h5000);
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("t5_hold_req", 32'(mem_req_o), 32'd1);
         chk("t5_no_err",   32'(bus_err_o), 32'd0);
      end
      tick();
      chk("t5_req_drop", 32'(mem_req_o),      32'd0);
      chk("t5_done",     32'(dm_load_done_o), 32'd1);
      chk("t5_data",     dm_data_l_o,         32'h0);
      chk("t5_err",      32'(bus_err_o),      32'd1);
      ack_en = 1'b1;
      tick();
      chk("t5_err_sticky", 32'(bus_err_o), 32'd1);
      chk("t5_fetch_next", mem_addr_o,     32'h400);
      dm_store_i = 1'b1; dm_addr_i = 32'h7000; dm_data_s_i = 32'hCAFE_F00D; dm_data_select_i = 4'hF;

      // Asynchronous reset in the middle of a stalled store.
      tick();
      dm_store_i = 1'b0;
      chk("t6_fvalid", 32'(im_valid_o), 32'd1);
      wait_n = 3;
      tick();
      chk("t6_dacc_req", 32'(mem_req_o), 32'd1);
      chk("t6_dacc_we",  32'(mem_we_o),  32'd1);
      chk("t6_dacc_adr", mem_addr_o,     32'h7000);
      #2 rst_i = 1'b1;
      #1;
      chk("t6_rst_req",   32'(mem_req_o),   32'd0);
      chk("t6_rst_we",    32'(mem_we_o),    32'd0);
      chk("t6_rst_addr",  mem_addr_o,       32'h0);
      chk("t6_rst_wdata", mem_wdata_o,      32'h0);
      chk("t6_rst_err",   32'(bus_err_o),   32'd0);
      chk("t6_rst_ldata", dm_data_l_o,      32'h0);
      chk("t6_rst_idata", im_data_o,        32'h0);
      tick();
      wait_n = 0;
      rst_i  = 1'b0;
      tick();
      chk("t6_ready",  32'(dm_ready_o),  32'd1);
      chk("t6_perr0",  32'(proto_err_o), 32'd0);
      chk("t6_freq",   mem_addr_o,       32'h400);
      dm_load_i = 1'b1; dm_store_i = 1'b1;
      dm_addr_i = 32'h6000; dm_data_s_i = 32'h1234_5678; dm_data_select_i = 4'hF;
      tick();
      dm_load_i = 1'b0; dm_store_i = 1'b0;
      chk("t6_perr1",  32'(proto_err_o), 32'd1);
      chk("t6_busy",   32'(dm_ready_o),  32'd0);
      tick();
      chk("t6_we",    32'(mem_we_o),  32'd1);
      chk("t6_addr",  mem_addr_o,     32'h6000);
      chk("t6_wdata", mem_wdata_o,    32'h1234_5678);
      chk("t6_sel",   32'(mem_sel_o), 32'hF);
      tick();
      chk("t6_sdone", 32'(dm_store_done_o), 32'd1);
      chk("t6_ldone", 32'(dm_load_done_o),  32'd0);
      chk("t6_ldata", dm_data_l_o,          32'h0);
      tick();
      chk("t6_ready_back", 32'(dm_ready_o),  32'd1);
      chk("t6_perr_stick", 32'(proto_err_o), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
